// File: rtl/au_nb_seq.sv
// au_nb_seq: multi-cycle arithmetic unit.
//   ADD/SUB complete one cycle after acceptance.
//   MUL (shift-add) and DIV (restoring) take WIDTH cycles, one iteration per cycle.
//   DIV by zero completes in one cycle with lo = all ones, hi = a, dz = 1.
//
// Optional feature: define AU_NB_OVF_EN to get a signed add/sub overflow flag.
// Without it, ovf is tied low.
//
// Ports
//   clk          sole clock; everything updates on its rising edge
//   rst          synchronous, active-high reset
//   a, b         operands (a = dividend, b = divisor for DIV)
//   ALUop        00 ADD, 01 SUB, 10 unsigned MUL, 11 unsigned DIV
//   start        request; taken only while ready = 1
//   ready        high in IDLE only
//   done         one-cycle pulse when results update
//   s, cout      add/sub result and carry out
//   hi, lo       product upper/lower half, or remainder/quotient
//   zero         result-is-zero flag
//   dz           divide-by-zero flag
//   ovf          signed add/sub overflow
//
// state | meaning
// IDLE  | waiting for start; ready = 1
// CALC  | MUL/DIV iterating, one step per cycle
// DONE  | results valid, done = 1; back to IDLE next cycle
module au_nb_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUop,
    input  logic             start,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             dz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Only the multiplicand (MUL) or divisor (DIV) is needed after acceptance;
    // the other operand seeds the working low register.
    logic             div_q, div_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] wh_q, wh_d;
    logic [WIDTH-1:0] wl_q, wl_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;
    logic             dz_q, dz_d;

    logic             src_div;
    logic [WIDTH-1:0] src_m;
    logic [WIDTH-1:0] src_h;
    logic [WIDTH-1:0] src_l;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   ddiff;
    logic [WIDTH-1:0] step_h;
    logic [WIDTH-1:0] step_l;
    logic [WIDTH:0]   asum;

`ifdef AU_NB_OVF_EN
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] bx;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        m_d     = m_q;
        wh_d    = wh_q;
        wl_d    = wl_q;
        s_d     = s_q;
        cout_d  = cout_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = zero_q;
        dz_d    = dz_q;
`ifdef AU_NB_OVF_EN
        ovf_d   = ovf_q;
        bx      = b ^ {WIDTH{ALUop[0]}};
`endif

        // The first iteration runs on the accepting edge straight from the
        // inputs so that WIDTH iterations fit in WIDTH cycles.
        if (state_q == CALC) begin
            src_div = div_q;
            src_m   = m_q;
            src_h   = wh_q;
            src_l   = wl_q;
        end else begin
            src_div = ALUop[0];
            src_m   = ALUop[0] ? b : a;
            src_h   = '0;
            src_l   = ALUop[0] ? a : b;
        end

        msum  = {1'b0, src_h} + (src_l[0] ? {1'b0, src_m} : {(WIDTH+1){1'b0}});
        // Partial remainder stays below the divisor, so the shifted value is
        // below 2*divisor and the sign of this difference is the restore flag.
        ddiff = {src_h, src_l[WIDTH-1]} - {1'b0, src_m};
        if (src_div) begin
            step_h = ddiff[WIDTH] ? {src_h[WIDTH-2:0], src_l[WIDTH-1]} : ddiff[WIDTH-1:0];
            step_l = {src_l[WIDTH-2:0], ~ddiff[WIDTH]};
        end else begin
            step_h = msum[WIDTH:1];
            step_l = {msum[0], src_l[WIDTH-1:1]};
        end

        asum = {1'b0, a} + {1'b0, b ^ {WIDTH{ALUop[0]}}} + {{WIDTH{1'b0}}, ALUop[0]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!ALUop[1]) begin
                        s_d     = asum[WIDTH-1:0];
                        cout_d  = asum[WIDTH];
                        zero_d  = (asum[WIDTH-1:0] == '0);
                        dz_d    = 1'b0;
`ifdef AU_NB_OVF_EN
                        ovf_d   = (a[WIDTH-1] == bx[WIDTH-1]) &&
                                  (asum[WIDTH-1] != a[WIDTH-1]);
`endif
                        state_d = DONE;
                    end else if (ALUop[0] && (b == '0)) begin
                        lo_d    = '1;
                        hi_d    = a;
                        zero_d  = 1'b0;
                        dz_d    = 1'b1;
`ifdef AU_NB_OVF_EN
                        ovf_d   = 1'b0;
`endif
                        state_d = DONE;
                    end else begin
                        div_d   = ALUop[0];
                        m_d     = src_m;
                        wh_d    = step_h;
                        wl_d    = step_l;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                wh_d  = step_h;
                wl_d  = step_l;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    hi_d    = step_h;
                    lo_d    = step_l;
                    zero_d  = (step_h == '0) && (step_l == '0);
                    dz_d    = 1'b0;
`ifdef AU_NB_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            m_q     <= '0;
            wh_q    <= '0;
            wl_q    <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b1;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            m_q     <= m_d;
            wh_q    <= wh_d;
            wl_q    <= wl_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
        end
    end

`ifdef AU_NB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign s     = s_q;
    assign cout  = cout_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign zero  = zero_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_au_nb_seq.sv
module tb_au_nb_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    logic [1:0]    ALUop;
    logic          start;
    logic          ready, done, cout, zero, dz, ovf;
    logic [W-1:0]  s, hi, lo;

    int vectors = 0;
    int errors  = 0;

    // Reference state: what the outputs should be holding.
    logic [W-1:0] m_s, m_hi, m_lo;
    logic         m_cout, m_zero, m_dz, m_ovf;

    au_nb_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .ALUop(ALUop), .start(start),
        .ready(ready), .done(done), .s(s), .cout(cout), .hi(hi), .lo(lo),
        .zero(zero), .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s = '0; m_hi = '0; m_lo = '0;
        m_cout = 1'b0; m_zero = 1'b1; m_dz = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int lat);
        longint          sx, sy, r;
        longint unsigned ux, uy, p;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            2'b00, 2'b01: begin
                if (op == 2'b00) begin
                    p      = ux + uy;
                    m_cout = (p >= 64'h1_0000_0000);
                    r      = sx + sy;
                end else begin
                    p      = ux - uy;
                    m_cout = (ux >= uy);
                    r      = sx - sy;
                end
                m_s    = p[W-1:0];
                m_zero = (m_s == 0);
                m_dz   = 1'b0;
`ifdef AU_NB_OVF_EN
                m_ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
                m_ovf  = 1'b0;
`endif
                lat = 1;
            end
            2'b10: begin
                p      = ux * uy;
                m_hi   = p[63:32];
                m_lo   = p[31:0];
                m_zero = (p == 0);
                m_dz   = 1'b0;
                m_ovf  = 1'b0;
                lat    = W;
            end
            default: begin
                m_ovf = 1'b0;
                if (y == 0) begin
                    m_lo   = 32'hFFFF_FFFF;
                    m_hi   = x;
                    m_zero = 1'b0;
                    m_dz   = 1'b1;
                    lat    = 1;
                end else begin
                    m_lo   = x / y;
                    m_hi   = x % y;
                    m_zero = (m_lo == 0) && (m_hi == 0);
                    m_dz   = 1'b0;
                    lat    = W;
                end
            end
        endcase
    endtask

    // Issues one operation and checks latency, holding behaviour and results.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit noise);
        int           exp_lat, lat;
        bit           got;
        logic [W-1:0] ps, ph, pl;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_op: got %b want 1", ready);
        end
        ps = m_s; ph = m_hi; pl = m_lo;
        model_apply(op, x, y, exp_lat);
        a = x; b = y; ALUop = op; start = 1'b1;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 80) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                got   = 1'b1;
                start = 1'b0;
            end else begin
                vectors++;
                if (ready !== 1'b0 || s !== ps || hi !== ph || lo !== pl) begin
                    errors++;
                    $display("FAIL busy_hold: ready=%b s=%h hi=%h lo=%h want ready=0 s=%h hi=%h lo=%h",
                             ready, s, hi, lo, ps, ph, pl);
                end
                if (noise) begin
                    start = 1'($urandom);
                    a     = $urandom;
                    b     = $urandom;
                    ALUop = 2'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: op=%0d no done within %0d cycles", op, lat);
        end else if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency: op=%0d got %0d want %0d", op, lat, exp_lat);
        end
        vectors++;
        if (s !== m_s || cout !== m_cout || hi !== m_hi || lo !== m_lo ||
            zero !== m_zero || dz !== m_dz || ovf !== m_ovf) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h: got s=%h c=%b hi=%h lo=%h z=%b dz=%b ovf=%b want s=%h c=%b hi=%h lo=%h z=%b dz=%b ovf=%b",
                     op, x, y, s, cout, hi, lo, zero, dz, ovf,
                     m_s, m_cout, m_hi, m_lo, m_zero, m_dz, m_ovf);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b ready=%b want done=0 ready=1", done, ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ALUop = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || s !== '0 || hi !== '0 || lo !== '0 ||
            cout !== 1'b0 || zero !== 1'b1 || dz !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b done=%b s=%h hi=%h lo=%h c=%b z=%b dz=%b ovf=%b",
                     ready, done, s, hi, lo, cout, zero, dz, ovf);
        end
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(2'b01, 32'd5, 32'd7, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'd1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        vectors++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mul_max: hi=%h lo=%h want fffffffe 00000001", hi, lo);
        end
        run_op(2'b11, 32'd100, 32'd7, 1'b1);
        vectors++;
        if (lo !== 32'd14 || hi !== 32'd2 || dz !== 1'b0) begin
            errors++;
            $display("FAIL div_100_7: lo=%0d hi=%0d dz=%b want 14 2 0", lo, hi, dz);
        end
        run_op(2'b11, 32'd9, 32'd0, 1'b0);
        run_op(2'b10, 32'd0, 32'h1234_5678, 1'b0);
        run_op(2'b11, 32'd3, 32'd10, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic [1:0]   op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'($urandom_range(0, 15));
                1: x = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(op, x, y, 1'b1);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h0000_1234; ALUop = 2'b10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_early_done: done=%b want 0", done);
            end
        end
        rst = 1'b1;
        start = 1'b1;
        ALUop = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        model_reset();
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || hi !== '0 || lo !== '0 || s !== '0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: ready=%b done=%b s=%h hi=%h lo=%h z=%b", ready, done, s, hi, lo, zero);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_late_done: done=%b want 0 at cycle %0d", done, i);
            end
        end
        run_op(2'b00, 32'd20, 32'd22, 1'b0);
    endtask

    task automatic test_back_to_back();
        int pulses;
        @(negedge clk);
        a = 32'd1; b = 32'd2; ALUop = 2'b00; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'(k % 2)) begin
                errors++;
                $display("FAIL b2b_add: cycle %0d done=%b want %b", k, done, 1'(k % 2));
            end
        end
        // Let the pending ADD drain, then stream MULs.
        start = 1'b0;
        repeat (3) @(negedge clk);
        ALUop = 2'b10; start = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                vectors++;
                if (k != W && k != 2 * W + 1) begin
                    errors++;
                    $display("FAIL b2b_mul_timing: done at cycle %0d want %0d or %0d", k, W, 2 * W + 1);
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_mul_count: got %0d pulses want 2", pulses);
        end
        repeat (W + 4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        test_back_to_back();
        run_op(2'b01, 32'd0, 32'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/au_nb_seq.md
AU_NB_SEQ -- requirements
Module: au_nb_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  WIDTH  operand A (dividend for divide).
REQ-005 b  input  WIDTH  operand B (divisor for divide).
REQ-006 ALUop  input  2  00 ADD, 01 SUB, 10 unsigned multiply, 11 unsigned divide.
REQ-007 start  input  1  request; accepted only when ready=1.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 done  output  1  one-cycle pulse when results update.
REQ-010 s  output  WIDTH  add/sub result.
REQ-011 cout  output  1  add/sub carry out.
REQ-012 hi  output  WIDTH  product upper half / remainder.
REQ-013 lo  output  WIDTH  product lower half / quotient.
REQ-014 zero  output  1  result-is-zero flag.
REQ-015 dz  output  1  divide-by-zero flag.
REQ-016 ovf  output  1  signed add/sub overflow (see Configuration).

Function
REQ-017 FSM states IDLE, CALC, DONE; start&&ready latches a, b, ALUop into internal registers; a, b, ALUop ignored at all other times.
REQ-018 ADD/SUB: IDLE->DONE on accepting edge; s = a + (b XOR {WIDTH{op0}}) + op0, cout = carry out of that sum; done high the cycle after acceptance (latency 1).
REQ-019 MUL/DIV: IDLE->CALC with iteration counter loaded to WIDTH-1; one iteration per cycle; CALC->DONE when counter reaches 0; done high WIDTH cycles after acceptance.
REQ-020 Multiply: shift-add, full 2*WIDTH unsigned product, {hi,lo} = a*b.
REQ-021 Divide: restoring, lo = a/b, hi = a%b, unsigned.
REQ-022 Divide with b=0: no iteration (IDLE->DONE, latency 1), lo = all ones, hi = a, dz=1; dz=0 on every other completed op.
REQ-023 DONE->IDLE unconditionally next cycle; start during CALC or DONE is ignored, not queued; back-to-back throughput one op per latency+1 cycles.
REQ-024 s/cout update only on ADD/SUB completion; hi/lo update only on MUL/DIV completion; every output holds between completions.
REQ-025 zero updates on every completion: ADD/SUB -> (s==0); MUL/DIV -> (hi==0 && lo==0).
REQ-026 Intermediate CALC values never appear on s, hi, lo.

Reset
REQ-027 rst=1 at a clock edge forces IDLE, clears counter and working registers, drives s, hi, lo to 0, cout, dz, ovf, done to 0, zero to 1, ready to 1 from the following cycle.
REQ-028 rst during CALC aborts the operation with no done pulse; rst has priority over start in the same cycle.

Configuration
REQ-029 Macro AU_NB_OVF_EN defined: ovf updates on ADD/SUB completion to signed two's-complement overflow of the result, cleared on MUL/DIV completion.
REQ-030 Macro AU_NB_OVF_EN undefined: ovf tied to 0, no overflow logic synthesised; all other behaviour identical.

Verification (WIDTH=32)
REQ-031 ADD a=0xFFFFFFFF b=0x00000001 -> 1 cycle later done=1, s=0, cout=1, zero=1; with AU_NB_OVF_EN ovf=0; ADD 0x7FFFFFFF+1 -> ovf=1.
REQ-032 SUB a=5 b=7 -> s=0xFFFFFFFE, cout=0, zero=0, latency 1.
REQ-033 MUL a=b=0xFFFFFFFF -> done exactly 32 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, s unchanged; start pulses mid-CALC ignored.
REQ-034 DIV a=100 b=7 -> after 32 cycles lo=14, hi=2, dz=0; DIV a=9 b=0 -> 1 cycle, lo=0xFFFFFFFF, hi=9, dz=1.
REQ-035 rst asserted at cycle 10 of a MUL -> no done, ready=1 next cycle, hi=lo=0, zero=1; new ADD then completes normally.
